// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int FETCH_ADDR_W  = 12;
    localparam int FETCH_INSTR_W = 32;

    // First fetch address after reset, as seen by the PC block.
    localparam logic [11:0] RESET_PC = 12'd256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {word, pc} entries for the decoder.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: pop is ignored when empty; push is ignored when full unless popping in the same cycle.
// Ports: clock/resetCPU; push/push_dat; pop; clear (discards all, wins over push/pop);
//        count (occupancy 0..DEPTH); head (oldest entry, zero when empty).
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 44
) (
    input  logic                     clock,
    input  logic                     resetCPU,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    input  logic                     clear,
    output logic [$clog2(DEPTH):0]   count,
    output logic [W-1:0]             head
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != '0);
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign do_push = push && ((count != FULL) || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge resetCPU) begin
        if (!resetCPU) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clock) begin
        if (do_push && !clear) mem[wr_ptr] <= push_dat;
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: reads memory at programCounter, buffers words for the decoder, holds the PC via HLT.
// Latency: zero-wait memory gives instr_valid two cycles after the PC is seen in IDLE; one fetch per two cycles.
// Backpressure: no request is issued while the buffer is full; HLT stays high until a word is captured.
// Ports: clock/resetCPU; programCounter in, HLT out; flush in; mem_req/mem_addr out, mem_ack/mem_rdata in;
//        instr_valid/instr/instr_pc out with instr_ready in (pop on valid & ready).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = FETCH_ADDR_W,
    parameter int INSTR_W = FETCH_INSTR_W,
    parameter int DEPTH   = 2
) (
    input  logic               clock,
    input  logic               resetCPU,
    input  logic [ADDR_W-1:0]  programCounter,
    output logic               HLT,
    input  logic               flush,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [INSTR_W-1:0] word;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    fetch_state_t   state_q;
    fetch_state_t   state_d;
    logic [CW-1:0]  count;
    logic           not_full;
    logic           accept;
    logic           pop;
    entry_t         push_ent;
    entry_t         head_ent;

    assign not_full = (count < CW'(DEPTH));
    assign accept   = (state_q == WAIT) && mem_ack && !flush;
    assign pop      = instr_valid && instr_ready;

    // Release the PC once per captured word, and on every flush so it can load the target.
    // Held high throughout reset regardless of flush.
    assign HLT = !resetCPU || !(accept || flush);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!flush && not_full) state_d = WAIT;
            end
            WAIT: begin
                if (mem_ack)    state_d = IDLE;
                else if (flush) state_d = DRAIN;
            end
            DRAIN: begin
                // The word in flight is discarded whenever it arrives; flush has nothing more to do.
                if (mem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetCPU) begin
        if (!resetCPU) begin
            state_q  <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            state_q <= state_d;
            mem_req <= (state_d == WAIT) || (state_d == DRAIN);
            if (state_q == IDLE && state_d == WAIT) mem_addr <= programCounter;
        end
    end

    assign push_ent.word = mem_rdata;
    assign push_ent.pc   = mem_addr;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .clock    (clock),
        .resetCPU (resetCPU),
        .push     (accept),
        .push_dat (push_ent),
        .pop      (pop),
        .clear    (flush),
        .count    (count),
        .head     (head_ent)
    );

    assign instr_valid = (count != '0);
    assign instr       = head_ent.word;
    assign instr_pc    = head_ent.pc;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int AW = FETCH_ADDR_W;
    localparam int IW = FETCH_INSTR_W;

    logic          clock = 1'b0;
    logic          resetCPU;
    logic [AW-1:0] programCounter;
    logic          HLT;
    logic          flush;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [IW-1:0] mem_rdata;
    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;

    always #5 clock = ~clock;

    fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(2)) dut (
        .clock          (clock),
        .resetCPU       (resetCPU),
        .programCounter (programCounter),
        .HLT            (HLT),
        .flush          (flush),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    typedef struct {
        logic [IW-1:0] word;
        logic [AW-1:0] pc;
    } exp_t;

    typedef struct {
        int            lat;
        logic [IW-1:0] data;
        logic [AW-1:0] pc;
    } vec_t;

    exp_t          exp_q[$];
    vec_t          vecs[4];
    int            passed = 0;
    int            total  = 0;
    logic [AW-1:0] jump_pc = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // PC block model: loads a new value at the edge only when HLT was low.
    task automatic tick();
        logic adv;
        logic jmp;
        @(negedge clock);
        adv = !HLT;
        jmp = flush;
        @(posedge clock);
        #1;
        if (adv) programCounter = jmp ? jump_pc : programCounter + 1'b1;
    endtask

    task automatic do_reset();
        resetCPU       = 1'b0;
        flush          = 1'b0;
        mem_ack        = 1'b0;
        mem_rdata      = '0;
        programCounter = RESET_PC;
        exp_q.delete();
        tick();
        tick();
        resetCPU = 1'b1;
    endtask

    // Waits (bounded) for a request, checks its address, acks after lat cycles.
    task automatic fetch_one(input int lat, input logic [IW-1:0] data, input logic [AW-1:0] exp_pc);
        int n = 0;
        while (!mem_req && n < 8) begin
            tick();
            n++;
        end
        chk("req_seen", mem_req, 1);
        chk("req_addr", mem_addr, exp_pc);
        for (int i = 0; i < lat; i++) begin
            #2;
            chk("wait_req_held", mem_req, 1);
            chk("wait_addr_held", mem_addr, exp_pc);
            chk("wait_hlt", HLT, 1);
            tick();
        end
        mem_ack   = 1'b1;
        mem_rdata = data;
        exp_q.push_back('{word: data, pc: exp_pc});
        #2;
        chk("hlt_on_accept", HLT, 0);
        tick();
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    // Scoreboard: every decoder handshake outside a flush must match the oldest expected word.
    always @(negedge clock) begin
        exp_t e;
        if (resetCPU && instr_valid && instr_ready && !flush) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL sb_empty: popped instr 0x%0h pc 0x%0h with nothing expected", instr, instr_pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_instr", instr, e.word);
                chk("sb_pc", instr_pc, e.pc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 32'h1111_0102, 12'h102};
        vecs[1] = '{1, 32'h2222_0103, 12'h103};
        vecs[2] = '{3, 32'h3333_0104, 12'h104};
        vecs[3] = '{0, 32'h4444_0105, 12'h105};

        // Reset values, HLT held even with flush high.
        resetCPU       = 1'b0;
        programCounter = RESET_PC;
        flush          = 1'b1;
        mem_ack        = 1'b0;
        mem_rdata      = '0;
        instr_ready    = 1'b1;
        #3;
        chk("rst_hlt", HLT, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        flush = 1'b0;
        do_reset();

        // Zero-wait fetch.
        #2;
        chk("idle_no_req", mem_req, 0);
        fetch_one(0, 32'hDEAD_BEEF, 12'h100);
        #2;
        chk("t1_valid", instr_valid, 1);
        chk("t1_instr", instr, 32'hDEAD_BEEF);
        chk("t1_pc", instr_pc, 12'h100);
        chk("t1_hlt_back_high", HLT, 1);

        // Ack delayed by 5 cycles.
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hCAFE_0101;
                exp_q.push_back('{word: 32'hCAFE_0101, pc: 12'h101});
            end
            #2;
            chk("t2_req", mem_req, 1);
            chk("t2_addr", mem_addr, 12'h101);
            chk("t2_hlt", HLT, (i == 5) ? 0 : 1);
            chk("t2_no_early_push", instr_valid, 0);
            tick();
        end
        mem_ack = 1'b0;

        // Table of fetches with assorted latencies.
        for (int v = 0; v < 4; v++) fetch_one(vecs[v].lat, vecs[v].data, vecs[v].pc);
        tick();
        chk("table_drained", exp_q.size(), 0);

        // Full buffer stalls fetch until the decoder pops.
        do_reset();
        instr_ready = 1'b0;
        fetch_one(0, 32'hA0A0_0100, 12'h100);
        fetch_one(2, 32'hB0B0_0101, 12'h101);
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("full_no_req", mem_req, 0);
            chk("full_hlt", HLT, 1);
            chk("full_head_pc", instr_pc, 12'h100);
            tick();
        end
        instr_ready = 1'b1;
        #2;
        chk("full_pop_instr", instr, 32'hA0A0_0100);
        tick();
        instr_ready = 1'b0;
        #2;
        chk("after_pop_pc", instr_pc, 12'h101);
        chk("after_pop_no_req_yet", mem_req, 0);
        tick();
        #2;
        chk("refill_req", mem_req, 1);
        chk("refill_addr", mem_addr, 12'h102);

        // Flush while waiting: DRAIN swallows the late word.
        do_reset();
        instr_ready = 1'b1;
        tick();
        flush   = 1'b1;
        jump_pc = 12'h040;
        exp_q.delete();
        #2;
        chk("wflush_hlt", HLT, 0);
        tick();
        flush = 1'b0;
        #2;
        chk("drain_req", mem_req, 1);
        chk("drain_addr", mem_addr, 12'h100);
        chk("drain_hlt", HLT, 1);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_1111;
        #2;
        chk("drain_ack_hlt", HLT, 1);
        tick();
        mem_ack = 1'b0;
        #2;
        chk("drain_discard_valid", instr_valid, 0);
        chk("drain_idle_req", mem_req, 0);
        tick();
        fetch_one(0, 32'h0400_0040, 12'h040);
        #2;
        chk("jump_valid", instr_valid, 1);
        chk("jump_pc", instr_pc, 12'h040);
        tick();
        chk("flush_drained", exp_q.size(), 0);

        // Flush with a stray ack and a pop while full.
        do_reset();
        instr_ready = 1'b0;
        fetch_one(0, 32'h5555_0100, 12'h100);
        fetch_one(0, 32'h6666_0101, 12'h101);
        flush       = 1'b1;
        jump_pc     = 12'h080;
        mem_ack     = 1'b1;
        mem_rdata   = 32'hBAD0_BAD0;
        instr_ready = 1'b1;
        exp_q.delete();
        #2;
        chk("fullflush_hlt", HLT, 0);
        tick();
        flush   = 1'b0;
        mem_ack = 1'b0;
        #2;
        chk("fullflush_valid", instr_valid, 0);
        chk("fullflush_no_req", mem_req, 0);
        tick();
        #2;
        chk("fullflush_req", mem_req, 1);
        chk("fullflush_addr", mem_addr, 12'h080);

        // Flush together with ack in WAIT and a pop, one word buffered.
        instr_ready = 1'b0;
        fetch_one(0, 32'h7777_0080, 12'h080);
        tick();
        flush       = 1'b1;
        jump_pc     = 12'h0C0;
        mem_ack     = 1'b1;
        mem_rdata   = 32'h8888_0081;
        instr_ready = 1'b1;
        exp_q.delete();
        #2;
        chk("ackflush_hlt", HLT, 0);
        tick();
        flush   = 1'b0;
        mem_ack = 1'b0;
        #2;
        chk("ackflush_valid", instr_valid, 0);
        chk("ackflush_not_drain", mem_req, 0);
        tick();
        #2;
        chk("ackflush_req", mem_req, 1);
        chk("ackflush_addr", mem_addr, 12'h0C0);

        // Async reset mid-WAIT with a word buffered.
        do_reset();
        instr_ready = 1'b0;
        fetch_one(0, 32'h9999_0100, 12'h100);
        tick();
        #2;
        chk("pre_arst_req", mem_req, 1);
        chk("pre_arst_valid", instr_valid, 1);
        resetCPU       = 1'b0;
        programCounter = RESET_PC;
        exp_q.delete();
        #1;
        chk("arst_req", mem_req, 0);
        chk("arst_valid", instr_valid, 0);
        chk("arst_hlt", HLT, 1);
        chk("arst_addr", mem_addr, 0);
        tick();
        tick();
        resetCPU = 1'b1;
        #2;
        chk("post_arst_idle", mem_req, 0);
        tick();
        #2;
        chk("post_arst_req", mem_req, 1);
        chk("post_arst_addr", mem_addr, 12'h100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch responder that sits on the other end of the program-counter interface.
- Consumes `programCounter`, issues req/ack reads to instruction memory, and buffers returned words for the decoder.
- Drives `HLT` back to the PC so the PC advances only after the word at the current address has been captured.
- Supports a flush on jump or taken branch, discarding buffered and in-flight words.

Parameters:
- ADDR_W, 12, width of `programCounter` and memory address.
- INSTR_W, 32, instruction word width.
- DEPTH, 2, instruction buffer entries (power of two, ≥ 2).

Ports:
- clock  in  1  single clock, rising edge.
- resetCPU  in  1  asynchronous, active-low reset.
- programCounter  in  ADDR_W  current PC value from the PC block.
- HLT  out  1  hold request to the PC; the PC loads a new value only when HLT=0.
- flush  in  1  jump or taken branch from control; discards fetched and in-flight words.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  ADDR_W  read address, held stable while mem_req=1.
- mem_ack  in  1  read complete, mem_rdata valid this cycle.
- mem_rdata  in  INSTR_W  instruction word from memory.
- instr_valid  out  1  buffer head valid.
- instr_ready  in  1  decoder accepts the head; pop when valid&ready.
- instr  out  INSTR_W  buffer head word.
- instr_pc  out  ADDR_W  address the head word was fetched from.

Behaviour:
- Reset (resetCPU=0, asynchronous):
  - state=IDLE, count=0, mem_req=0, mem_addr=0.
  - instr_valid=0, instr=0, instr_pc=0.
  - HLT=1 while reset is held.
  - An in-flight memory request is abandoned; memory must tolerate mem_req dropping without ack.
- FSM states: IDLE, WAIT, DRAIN. mem_req is registered and equals (state==WAIT || state==DRAIN).
- IDLE:
  - If !flush and count<DEPTH: latch mem_addr<=programCounter and go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - ack & !flush: push {mem_rdata, mem_addr}, go to IDLE.
  - ack & flush: discard the word, go to IDLE.
  - !ack & flush: go to DRAIN.
  - !ack & !flush: stay in WAIT with mem_addr unchanged.
- DRAIN:
  - ack: discard the word, go to IDLE.
  - flush is ignored in DRAIN (the word is already being discarded).
- HLT is combinational: HLT = ~(accept | flush), where accept = (state==WAIT & mem_ack & !flush).
  - HLT is therefore low for exactly one cycle per captured word, and in every flush cycle so the PC can load the jump or branch target.
- Timing:
  - Zero-wait memory: PC stable in IDLE at cycle t, mem_req=1 at t+1, ack at t+1, instr_valid=1 at t+2, PC increments at the t+1 edge.
  - Peak rate is 1 fetch per 2 cycles.
- Buffer: FIFO of DEPTH entries with a count register.
  - Push only from WAIT on accept. Requests are issued only when count<DEPTH, so overflow cannot occur.
  - Simultaneous push and pop: count is unchanged and the head advances correctly, including at count==DEPTH-1 and count==DEPTH.
  - Pointers wrap modulo DEPTH.
  - instr_valid = (count!=0).
- Flush: count<=0 and pointers reset.
  - Flush takes priority over push and pop in the same cycle.
  - Words pending in the buffer are never presented after a flush.
- No ack is expected while mem_req=0. A stray ack in IDLE is ignored.

Decomposition:
- Shared package fetch_pkg:
  - ADDR_W and INSTR_W defaults.
  - State encoding constants IDLE=2'd0, WAIT=2'd1, DRAIN=2'd2.
  - RESET_PC=12'd256 for benches.
- One sub-module, fetch_fifo (parameterised DEPTH and width, with push, pop, clear, count, head), instantiated with width INSTR_W+ADDR_W.
- FSM and HLT logic stay in fetch_unit.

Test Plan:
- Reset, programCounter=0x100, ack on the first mem_req cycle with mem_rdata=0xDEADBEEF -> mem_addr=0x100, HLT low one cycle, next cycle instr_valid=1, instr=0xDEADBEEF, instr_pc=0x100.
- Ack delayed 5 cycles -> mem_req=1 and mem_addr stable for 6 cycles, HLT=1 throughout, no push before ack.
- instr_ready=0, fetch 0x100 and 0x101 -> count=2, no third mem_req, HLT stays 1. Then ready=1 for one cycle -> pop of 0x100 and a new request for 0x102 on the following IDLE cycle.
- Flush during WAIT, ack 2 cycles later with 0x11111111 -> state DRAIN, word discarded, instr_valid=0, next request at the new PC 0x040.
- Flush in the same cycle as ack and as pop with count=2 -> count=0, instr_valid=0 next cycle, HLT=0 in the flush cycle.
- Async reset asserted mid-WAIT -> mem_req, instr_valid and count go to 0 immediately without a clock edge. After release the first request is at programCounter=0x100.
